// File: rtl/counter_bank.sv
// counter_bank
//   Bank of CHANNELS independent WIDTH-bit programmable counters. Each channel
//   can be a toggle divider, a periodic pulse generator, a one-shot timeout, or
//   stopped. The bank is the shared timing source for strobes, divided clocks
//   and timeouts, and it is programmed one channel at a time through a
//   single-cycle config write port.
//
// Ports
//   clk        system clock, all logic on posedge
//   rst_n      asynchronous active-low reset
//   cfg_we     config write strobe (one cycle)
//   cfg_ch     channel targeted by the write; values >= CHANNELS are ignored
//   cfg_value  terminal count V loaded by the write
//   cfg_mode   00 toggle, 01 pulse, 10 one-shot, 11 stop
//   en         per-channel count enable
//   out        per-channel registered output
//   tick       per-channel one-cycle pulse after each terminal event
//
// Optional feature, enabled by defining COUNTER_BANK_IRQ_EN:
//   irq_clr    per-channel pending-interrupt clear
//   irq_pend   per-channel pending flag, set by tick, cleared by irq_clr
//   irq        registered OR of all pending flags

module counter_bank #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_we,
  input  logic [$clog2(CHANNELS)-1:0] cfg_ch,
  input  logic [WIDTH-1:0]            cfg_value,
  input  logic [1:0]                  cfg_mode,
  input  logic [CHANNELS-1:0]         en,
  output logic [CHANNELS-1:0]         out,
  output logic [CHANNELS-1:0]         tick
`ifdef COUNTER_BANK_IRQ_EN
  ,
  input  logic [CHANNELS-1:0]         irq_clr,
  output logic [CHANNELS-1:0]         irq_pend,
  output logic                        irq
`endif
);

  localparam int CH_W = $clog2(CHANNELS);

  typedef enum logic [1:0] {
    MODE_TOGGLE  = 2'b00,
    MODE_PULSE   = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_STOP    = 2'b11
  } mode_e;

  logic [WIDTH-1:0]    count_q [CHANNELS];
  logic [WIDTH-1:0]    value_q [CHANNELS];
  mode_e               mode_q  [CHANNELS];

  logic [CHANNELS-1:0] wr_hit;
  logic [CHANNELS-1:0] fired;
  logic [CHANNELS-1:0] terminal;

  // A write decodes to at most one channel. Matching against each channel
  // index means an out-of-range cfg_ch simply hits nothing. A one-shot that
  // has already fired sits at count==value with out=1; it is excluded from
  // the terminal condition so that it ticks only once.
  always_comb begin
    wr_hit   = '0;
    fired    = '0;
    terminal = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_hit[i]   = cfg_we && (cfg_ch == CH_W'(i));
      fired[i]    = (mode_q[i] == MODE_ONESHOT) && out[i];
      terminal[i] = (count_q[i] == value_q[i]) && (mode_q[i] != MODE_STOP) && !fired[i];
    end
  end

  // Per-channel counter. Priority: config write, stop mode, enable gate,
  // fired one-shot hold, terminal event, plain increment. A write always
  // clears count, so lowering V below the live count never causes a wrap.
  // With en low both count and out hold, including a pulse output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        count_q[i] <= '0;
        value_q[i] <= '1;
        mode_q[i]  <= MODE_TOGGLE;
      end
      out  <= '0;
      tick <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_hit[i]) begin
          value_q[i] <= cfg_value;
          mode_q[i]  <= mode_e'(cfg_mode);
          count_q[i] <= '0;
          out[i]     <= 1'b0;
          tick[i]    <= 1'b0;
        end else if (mode_q[i] == MODE_STOP) begin
          count_q[i] <= '0;
          out[i]     <= 1'b0;
          tick[i]    <= 1'b0;
        end else if (!en[i]) begin
          tick[i] <= 1'b0;
        end else if (fired[i]) begin
          tick[i] <= 1'b0;
        end else if (terminal[i]) begin
          tick[i] <= 1'b1;
          case (mode_q[i])
            MODE_TOGGLE: begin
              count_q[i] <= '0;
              out[i]     <= ~out[i];
            end
            MODE_PULSE: begin
              count_q[i] <= '0;
              out[i]     <= 1'b1;
            end
            MODE_ONESHOT: begin
              out[i] <= 1'b1;
            end
            default: begin
              count_q[i] <= '0;
              out[i]     <= 1'b0;
            end
          endcase
        end else begin
          count_q[i] <= count_q[i] + WIDTH'(1);
          tick[i]    <= 1'b0;
          if (mode_q[i] == MODE_PULSE) begin
            out[i] <= 1'b0;
          end
        end
      end
    end
  end

`ifdef COUNTER_BANK_IRQ_EN
  // Pending flags follow the registered tick, so they rise one cycle after
  // it. A tick arriving together with a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_pend <= '0;
      irq      <= 1'b0;
    end else begin
      irq_pend <= tick | (irq_pend & ~irq_clr);
      irq      <= |irq_pend;
    end
  end
`endif

endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank
//   Self-checking bench for counter_bank (WIDTH=16, CHANNELS=4). A hand-computed
//   vector table, directed multi-cycle sequences and a randomized phase are
//   compared against constants and against a reference model that derives
//   every output from the number of enabled cycles since the last write.
//   Build with COUNTER_BANK_IRQ_EN defined to include the interrupt checks.

`timescale 1ns/1ps

module tb_counter_bank;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_value;
  logic [1:0]  cfg_mode;
  logic [3:0]  en;
  logic [3:0]  out;
  logic [3:0]  tick;
`ifdef COUNTER_BANK_IRQ_EN
  logic [3:0]  irq_clr;
  logic [3:0]  irq_pend;
  logic        irq;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  counter_bank #(.WIDTH(16), .CHANNELS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_value (cfg_value),
    .cfg_mode  (cfg_mode),
    .en        (en),
    .out       (out),
    .tick      (tick)
`ifdef COUNTER_BANK_IRQ_EN
    ,
    .irq_clr   (irq_clr),
    .irq_pend  (irq_pend),
    .irq       (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per channel, the number of enabled cycles n since the
  // last write, the terminal value, the mode and whether the latest edge
  // was an enabled one.
  int         n_m  [4];
  int         v_m  [4];
  logic [1:0] m_m  [4];
  bit         le_m [4];
`ifdef COUNTER_BANK_IRQ_EN
  logic [3:0] pend_m;
  logic       irq_m;
`endif

  function automatic logic [3:0] model_tick();
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      case (m_m[i])
        2'b00, 2'b01: r[i] = le_m[i] && (n_m[i] > 0) && ((n_m[i] % (v_m[i] + 1)) == 0);
        2'b10:        r[i] = le_m[i] && (n_m[i] == v_m[i] + 1);
        default:      r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  function automatic logic [3:0] model_out();
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      case (m_m[i])
        2'b00:   r[i] = ((n_m[i] / (v_m[i] + 1)) % 2) == 1;
        2'b01:   r[i] = (n_m[i] > 0) && ((n_m[i] % (v_m[i] + 1)) == 0);
        2'b10:   r[i] = n_m[i] >= v_m[i] + 1;
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      n_m[i]  = 0;
      v_m[i]  = 65535;
      m_m[i]  = 2'b00;
      le_m[i] = 1'b0;
    end
`ifdef COUNTER_BANK_IRQ_EN
    pend_m = '0;
    irq_m  = 1'b0;
`endif
  endtask

  task automatic model_step(input logic we, input logic [1:0] ch, input logic [15:0] val,
                            input logic [1:0] md, input logic [3:0] e);
`ifdef COUNTER_BANK_IRQ_EN
    logic [3:0] tick_pre;
    tick_pre = model_tick();
    irq_m    = |pend_m;
    pend_m   = tick_pre | (pend_m & ~irq_clr);
`endif
    for (int i = 0; i < 4; i++) begin
      if (we && (int'(ch) == i)) begin
        v_m[i]  = int'(val);
        m_m[i]  = md;
        n_m[i]  = 0;
        le_m[i] = 1'b0;
      end else if (m_m[i] != 2'b11) begin
        le_m[i] = e[i];
        if (e[i]) n_m[i] = n_m[i] + 1;
      end
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic checkOutput(input string name);
    check_val({name, " out"},  32'(out),  32'(model_out()));
    check_val({name, " tick"}, 32'(tick), 32'(model_tick()));
`ifdef COUNTER_BANK_IRQ_EN
    check_val({name, " irq_pend"}, 32'(irq_pend), 32'(pend_m));
    check_val({name, " irq"},      32'(irq),      32'(irq_m));
`endif
  endtask

  // Drives one cycle of inputs, lets one rising edge pass, advances the model
  // and returns 1ns after the edge so outputs are sampled away from it.
  task automatic applyStimulus(input logic we, input logic [1:0] ch, input logic [15:0] val,
                               input logic [1:0] md, input logic [3:0] e);
    cfg_we    = we;
    cfg_ch    = ch;
    cfg_value = val;
    cfg_mode  = md;
    en        = e;
    @(posedge clk);
    model_step(we, ch, val, md, e);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  ch;
    logic [15:0] val;
    logic [1:0]  mode;
    logic [3:0]  en;
    logic [3:0]  exp_out;
    logic [3:0]  exp_tick;
  } vec_t;

  vec_t vecs[18];

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic        r_we;
    logic [1:0]  r_ch;
    logic [15:0] r_val;
    logic [1:0]  r_md;
    logic [3:0]  r_en;
    logic [3:0]  e_out;
    logic [3:0]  e_tick;

    // ch0 toggle V=3, ch1 pulse V=0 then V=2, ch2 one-shot V=5 then stop.
    vecs[0]  = '{1'b1, 2'd0, 16'd3, 2'b00, 4'b0000, 4'b0000, 4'b0000};
    vecs[1]  = '{1'b1, 2'd1, 16'd0, 2'b01, 4'b0001, 4'b0000, 4'b0000};
    vecs[2]  = '{1'b1, 2'd2, 16'd5, 2'b10, 4'b0011, 4'b0010, 4'b0010};
    vecs[3]  = '{1'b0, 2'd0, 16'd0, 2'b00, 4'b0111, 4'b0010, 4'b0010};
    vecs[4]  = '{1'b0, 2'd0, 16'd0, 2'b00, 4'b0111, 4'b0011, 4'b0011};
    vecs[5]  = '{1'b0, 2'd0, 16'd0, 2'b00, 4'b0111, 4'b0011, 4'b0010};
    vecs[6]  = '{1'b0, 2'd0, 16'd0, 2'b00, 4'b0111, 4'b0011, 4'b0010};
    vecs[7]  = '{1'b0, 2'd0, 16'd0, 2'b00, 4'b0111, 4'b0011, 4'b0010};
    vecs[8]  = '{1'b0, 2'd0, 16'd0, 2'b00, 4'b0111, 4'b0110, 4'b0111};
    vecs[9]  = '{1'b0, 2'd0, 16'd0, 2'b00, 4'b0111, 4'b0110, 4'b0010};
    vecs[10] = '{1'b0, 2'd0, 16'd0, 2'b00, 4'b0110, 4'b0110, 4'b0010};
    vecs[11] = '{1'b1, 2'd1, 16'd2, 2'b01, 4'b0111, 4'b0100, 4'b0000};
    vecs[12] = '{1'b0, 2'd0, 16'd0, 2'b00, 4'b0111, 4'b0100, 4'b0000};
    vecs[13] = '{1'b0, 2'd0, 16'd0, 2'b00, 4'b0111, 4'b0101, 4'b0001};
    vecs[14] = '{1'b0, 2'd0, 16'd0, 2'b00, 4'b0111, 4'b0111, 4'b0010};
    vecs[15] = '{1'b0, 2'd0, 16'd0, 2'b00, 4'b0111, 4'b0101, 4'b0000};
    vecs[16] = '{1'b1, 2'd2, 16'd0, 2'b11, 4'b0111, 4'b0001, 4'b0000};
    vecs[17] = '{1'b0, 2'd0, 16'd0, 2'b00, 4'b1111, 4'b0010, 4'b0011};

    rst_n     = 1'b0;
    cfg_we    = 1'b0;
    cfg_ch    = '0;
    cfg_value = '0;
    cfg_mode  = '0;
    en        = '0;
`ifdef COUNTER_BANK_IRQ_EN
    irq_clr   = '0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("reset out",  32'(out),  32'd0);
    check_val("reset tick", 32'(tick), 32'd0);
    rst_n = 1'b1;

    // Table-driven vectors with hand-computed expectations.
    for (int k = 0; k < 18; k++) begin
      applyStimulus(vecs[k].we, vecs[k].ch, vecs[k].val, vecs[k].mode, vecs[k].en);
      check_val($sformatf("vec%0d out", k),  32'(out),  32'(vecs[k].exp_out));
      check_val($sformatf("vec%0d tick", k), 32'(tick), 32'(vecs[k].exp_tick));
    end

    // Asynchronous reset between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async reset out",  32'(out),  32'd0);
    check_val("async reset tick", 32'(tick), 32'd0);
    #2;
    rst_n = 1'b1;
    model_reset();
    applyStimulus(1'b0, 2'd0, 16'd0, 2'b00, 4'b1111);
    checkOutput("post reset");

    // Enable gap: en[0] low for 3 cycles delays the first tick by 3 cycles.
    applyStimulus(1'b1, 2'd0, 16'd3, 2'b00, 4'b0001);
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(1'b0, 2'd0, 16'd0, 2'b00, {3'b000, !(k >= 3 && k <= 5)});
      check_val($sformatf("en gap k%0d tick0", k), 32'(tick[0]), 32'(k == 7));
      check_val($sformatf("en gap k%0d out0", k),  32'(out[0]),  32'(k >= 7));
    end

    // Collision: a rewrite on the terminal cycle suppresses the tick.
    applyStimulus(1'b1, 2'd0, 16'd3, 2'b00, 4'b0001);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(k == 4, 2'd0, 16'd3, 2'b00, 4'b0001);
      check_val($sformatf("collide k%0d tick0", k), 32'(tick[0]), 32'(k == 8));
      check_val($sformatf("collide k%0d out0", k),  32'(out[0]),  32'(k == 8));
    end

    // One-shot: single tick 6 cycles after the write, out sticky.
    applyStimulus(1'b1, 2'd2, 16'd5, 2'b10, 4'b0100);
    for (int k = 1; k <= 26; k++) begin
      applyStimulus(1'b0, 2'd0, 16'd0, 2'b00, 4'b0100);
      check_val($sformatf("oneshot k%0d tick2", k), 32'(tick[2]), 32'(k == 6));
      check_val($sformatf("oneshot k%0d out2", k),  32'(out[2]),  32'(k >= 6));
    end

`ifdef COUNTER_BANK_IRQ_EN
    // Interrupt flags: set by tick, cleared by irq_clr, set wins on a tie.
    irq_clr = 4'b1111;
    applyStimulus(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000);
    applyStimulus(1'b0, 2'd0, 16'd0, 2'b00, 4'b0000);
    irq_clr = 4'b0000;
    applyStimulus(1'b1, 2'd3, 16'd1, 2'b01, 4'b1000);
    for (int k = 1; k <= 5; k++) begin
      irq_clr = (k >= 4) ? 4'b1000 : 4'b0000;
      applyStimulus(1'b0, 2'd0, 16'd0, 2'b00, 4'b1000);
      checkOutput($sformatf("irq k%0d", k));
    end
    check_val("irq tie pend3", 32'(irq_pend[3]), 32'd1);
    irq_clr = 4'b0000;
`endif

    // Randomized phase against the reference model.
    for (int k = 0; k < 400; k++) begin
      r_we  = ($urandom_range(0, 7) == 0);
      r_ch  = 2'($urandom_range(0, 3));
      r_val = 16'($urandom_range(0, 6));
      r_md  = 2'($urandom_range(0, 3));
      for (int j = 0; j < 4; j++) r_en[j] = ($urandom_range(0, 4) != 0);
`ifdef COUNTER_BANK_IRQ_EN
      for (int j = 0; j < 4; j++) irq_clr[j] = ($urandom_range(0, 3) == 0);
`endif
      applyStimulus(r_we, r_ch, r_val, r_md, r_en);
      e_out  = model_out();
      e_tick = model_tick();
      check_val($sformatf("rand%0d out", k),  32'(out),  32'(e_out));
      check_val($sformatf("rand%0d tick", k), 32'(tick), 32'(e_tick));
`ifdef COUNTER_BANK_IRQ_EN
      check_val($sformatf("rand%0d irq_pend", k), 32'(irq_pend), 32'(pend_m));
      check_val($sformatf("rand%0d irq", k),      32'(irq),      32'(irq_m));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
